// File: rtl/vga_pkg.sv
// Shared types and default widths for the framebuffer arbiter slice.
package vga_pkg;

  localparam int DEF_ADDR_W     = 19;  // 640*480 = 307200 words
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    TURN,
    READ
  } arb_state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } fb_wr_t;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Host pixel-write bus: valid/ready handshake carrying one address/data word.
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = vga_pkg::DEF_ADDR_W,
  parameter int DATA_W = vga_pkg::DEF_DATA_W
);

  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;

  modport master (output valid, addr, wdata, input  ready);
  modport slave  (input  valid, addr, wdata, output ready);

endinterface

// File: rtl/vga_wr_fifo.sv
// Host write buffer: fb_wr_t entries, first-word-fall-through head, synchronous flush on reset.
module vga_wr_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH  // power of two, >= 2
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  logic   pop,
  input  fb_wr_t din,
  output fb_wr_t dout,
  output logic   full,
  output logic   empty
);

  localparam int PW = $clog2(DEPTH);

  fb_wr_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  // A full FIFO refuses the push even when it is popped in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display reads win, host writes drain in blanking via a FIFO.
// Optional stall statistics when VGA_ARB_STATS_EN is defined.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                disp_soon,
  input  logic                disp_req,
  input  logic [ADDR_W-1:0]   disp_addr,
  output logic [DATA_W-1:0]   disp_rdata,
  output logic                disp_rvalid,
  vga_fb_arbiter_if.slave     host,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                err_preempt,
  output logic [15:0]         host_stall_cnt
);

  arb_state_t st;
  fb_wr_t     head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;
  logic       rd_pend;

  assign host.ready = !fifo_full;
  assign push       = host.valid && host.ready;
  // A write issues only with no display activity now or next cycle, and never straight after a read.
  assign pop        = !disp_req && !disp_soon && !fifo_empty && (st != READ);

  vga_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ('{addr: host.addr, data: host.wdata}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      st          <= IDLE;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      rd_pend     <= 1'b0;
      disp_rvalid <= 1'b0;
      disp_rdata  <= '0;
      err_preempt <= 1'b0;
    end else begin
      mem_we      <= 1'b0;
      rd_pend     <= disp_req;
      disp_rvalid <= rd_pend;
      if (rd_pend) disp_rdata <= mem_rdata;
      // Being in WRITE implies disp_soon was low last cycle, so this is an unannounced read.
      err_preempt <= disp_req && (st == WRITE);

      if (disp_req) begin
        st       <= READ;
        mem_addr <= disp_addr;
      end else if (pop) begin
        st        <= WRITE;
        mem_addr  <= head.addr;
        mem_wdata <= head.data;
        mem_we    <= 1'b1;
      end else if (st == WRITE || (!disp_soon && st == READ && !fifo_empty)) begin
        st <= TURN;
      end else begin
        st <= IDLE;
      end
    end
  end

`ifdef VGA_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      host_stall_cnt <= '0;
    end else if (host.valid && !host.ready && host_stall_cnt != 16'hFFFF) begin
      host_stall_cnt <= host_stall_cnt + 1'b1;
    end
  end
`else
  assign host_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: scoreboard of buffered writes, reference image, timing rules.
module tb_vga_fb_arbiter;
  import vga_pkg::*;

  localparam int AW    = DEF_ADDR_W;
  localparam int DW    = DEF_DATA_W;
  localparam int DEPTH = DEF_FIFO_DEPTH;
  localparam int MEMN  = 2048;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          disp_soon = 1'b0;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic [DW-1:0] disp_rdata;
  logic          disp_rvalid;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          err_preempt;
  logic [15:0]   host_stall_cnt;

  vga_fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) host_if ();

  always #5 clk = ~clk;

  vga_fb_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .disp_soon      (disp_soon),
    .disp_req       (disp_req),
    .disp_addr      (disp_addr),
    .disp_rdata     (disp_rdata),
    .disp_rvalid    (disp_rvalid),
    .host           (host_if),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .err_preempt    (err_preempt),
    .host_stall_cnt (host_stall_cnt)
  );

  // SRAM: combinational read of the registered address, write at the clock edge.
  logic [DW-1:0] sram    [MEMN];
  logic [DW-1:0] ref_mem [MEMN];
  assign mem_rdata = sram[mem_addr[10:0]];
  always @(posedge clk) if (mem_we) sram[mem_addr[10:0]] <= mem_wdata;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: accepted writes queue up and must leave in order, only when the bus is free.
  fb_wr_t        wq[$];
  fb_wr_t        mon_e;
  int            stall_exp = 0;
  int            wr_cnt = 0, rv_cnt = 0, err_cnt = 0, cyc = 0;
  int            wr_cyc[$];
  logic          exp_ready;
  logic          p_reset = 1'b1, p_exp_ready = 1'b1, prev_we = 1'b0;
  logic          p_req = 1'b0, pp_req = 1'b0, p_soon = 1'b0, pp_soon = 1'b0, p_valid = 1'b0;
  logic [AW-1:0] p_addr = '0, pp_addr = '0, p_haddr = '0;
  logic [DW-1:0] p_hdata = '0;

  always @(negedge clk) begin
    cyc++;
    if (p_reset) begin
      wq.delete();
      stall_exp   = 0;
      p_req       = 1'b0;
      pp_req      = 1'b0;
      p_soon      = 1'b0;
      pp_soon     = 1'b0;
      p_valid     = 1'b0;
      prev_we     = 1'b0;
      p_exp_ready = 1'b1;
    end else begin
      check("rvalid_latency", disp_rvalid, pp_req);
      if (pp_req) check("rdata", disp_rdata, ref_mem[pp_addr[10:0]]);
      if (disp_rvalid) rv_cnt++;
      if (mem_we) begin
        wr_cnt++;
        wr_cyc.push_back(cyc);
        check("wr_bus_free", {p_req, p_soon, pp_req}, 0);
        check("wr_pending", wq.size() > 0, 1);
        if (wq.size() > 0) begin
          mon_e = wq.pop_front();
          check("wr_addr", mem_addr, mon_e.addr);
          check("wr_data", mem_wdata, mon_e.data);
          ref_mem[mon_e.addr[10:0]] = mon_e.data;
        end
      end
      if (p_valid && p_exp_ready) wq.push_back('{addr: p_haddr, data: p_hdata});
      if (p_valid && !p_exp_ready && stall_exp < 65535) stall_exp++;
      exp_ready = (wq.size() < DEPTH);
      check("host_ready", host_if.ready, exp_ready);
      check("err_preempt", err_preempt, p_req && prev_we && !pp_soon);
      if (err_preempt) err_cnt++;
`ifdef VGA_ARB_STATS_EN
      check("stall_cnt", host_stall_cnt, stall_exp);
`else
      check("stall_cnt", host_stall_cnt, 0);
`endif
      p_exp_ready = exp_ready;
    end
    pp_req  = p_req;
    pp_addr = p_addr;
    pp_soon = p_soon;
    p_req   = disp_req;
    p_addr  = disp_addr;
    p_soon  = disp_soon;
    p_valid = host_if.valid;
    p_haddr = host_if.addr;
    p_hdata = host_if.wdata;
    prev_we = mem_we;
    p_reset = reset;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_mism(output int n);
    n = 0;
    for (int i = 0; i < MEMN; i++) if (sram[i] !== ref_mem[i]) n++;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  int w0, rv0, e0, mism, accepted, first_stall_at;
  logic acc;

  initial begin
    host_if.valid = 1'b0;
    host_if.addr  = '0;
    host_if.wdata = '0;
    for (int i = 0; i < MEMN; i++) begin
      sram[i]    = DW'($urandom);
      ref_mem[i] = sram[i];
    end

    // 1: reset held for two edges
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rvalid", disp_rvalid, 0);
    check("rst_rdata", disp_rdata, 0);
    check("rst_err", err_preempt, 0);
    check("rst_stall", host_stall_cnt, 0);
    check("rst_ready", host_if.ready, 1);
    tick();

    // 2: blanking drain of three writes
    repeat (3) tick();
    w0 = wr_cnt;
    wr_cyc.delete();
    for (int k = 0; k < 3; k++) begin
      host_if.valid = 1'b1;
      host_if.addr  = AW'(32'h100 + k);
      host_if.wdata = DW'(32'hA1 + k);
      tick();
    end
    host_if.valid = 1'b0;
    repeat (8) tick();
    check("drain_cnt", wr_cnt - w0, 3);
    check("drain_consec", (wr_cyc.size() == 3) ? wr_cyc[2] - wr_cyc[0] : -1, 2);
    check("drain_sram0", sram[11'h100], 8'hA1);
    check("drain_sram2", sram[11'h102], 8'hA3);

    // 3: writes in flight, disp_soon, then a 640-pixel line
    repeat (5) tick();
    w0 = wr_cnt;
    for (int k = 0; k < 3; k++) begin
      host_if.valid = 1'b1;
      host_if.addr  = AW'(700 + k);
      host_if.wdata = DW'($urandom);
      tick();
    end
    host_if.valid = 1'b0;
    disp_soon = 1'b1;
    tick();
    disp_soon = 1'b0;
    check("pre_scan_writes", wr_cnt - w0, 2);
    for (int a = 0; a < 640; a++) begin
      disp_req  = 1'b1;
      disp_addr = AW'(a);
      if (a == 0) begin
        @(negedge clk);
        check("turn_before_read", mem_we, 0);
        w0  = wr_cnt;
        rv0 = rv_cnt;
      end
      tick();
    end
    disp_req = 1'b0;
    tick();
    tick();
    check("scan_no_write", wr_cnt - w0, 0);
    check("scan_pixels", rv_cnt - rv0, 640);
    repeat (10) tick();
    check("scan_tail_drained", wq.size(), 0);

    // 4: host floods the FIFO during active video
    repeat (5) tick();
    accepted = 0;
    first_stall_at = -1;
    disp_soon = 1'b1;
    tick();
    disp_soon = 1'b0;
    fork
      begin
        for (int a = 0; a < 640; a++) begin
          disp_req  = 1'b1;
          disp_addr = AW'(a);
          tick();
        end
        disp_req = 1'b0;
      end
      begin
        repeat (10) tick();
        for (int i = 0; i < 20; i++) begin
          host_if.valid = 1'b1;
          host_if.addr  = AW'($urandom_range(0, MEMN - 1));
          host_if.wdata = DW'($urandom);
          acc = 1'b0;
          for (int w = 0; w < 3000 && !acc; w++) begin
            @(negedge clk);
            if (host_if.ready) acc = 1'b1;
            else if (first_stall_at < 0) first_stall_at = accepted;
            tick();
          end
          check("host_accept", acc, 1);
          accepted++;
        end
        host_if.valid = 1'b0;
      end
    join
    repeat (80) tick();
    check("full_after", first_stall_at, DEPTH);
    check("all_accepted", accepted, 20);
    check("flood_drained", wq.size(), 0);
    count_mism(mism);
    check("flood_sram", mism, 0);
`ifdef VGA_ARB_STATS_EN
    check("flood_stalls", host_stall_cnt, stall_exp);
`else
    check("flood_stalls", host_stall_cnt, 0);
`endif

    // 5: unannounced display read in the middle of a drain
    repeat (5) tick();
    e0 = err_cnt;
    w0 = wr_cnt;
    for (int c = 0; c < 6; c++) begin
      host_if.valid = (c < 4);
      host_if.addr  = AW'($urandom_range(0, MEMN - 1));
      host_if.wdata = DW'($urandom);
      disp_req      = (c >= 3);
      disp_addr     = AW'($urandom_range(0, MEMN - 1));
      tick();
    end
    host_if.valid = 1'b0;
    disp_req = 1'b0;
    repeat (20) tick();
    check("preempt_pulses", err_cnt - e0, 1);
    check("preempt_writes", wr_cnt - w0, 4);
    check("preempt_drained", wq.size(), 0);
    count_mism(mism);
    check("preempt_sram", mism, 0);

    // 6: reset with five writes still buffered
    repeat (5) tick();
    disp_soon = 1'b1;
    tick();
    disp_soon = 1'b0;
    disp_req  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      host_if.valid = 1'b1;
      host_if.addr  = AW'($urandom_range(0, MEMN - 1));
      host_if.wdata = DW'($urandom);
      disp_addr     = AW'(k);
      tick();
    end
    host_if.valid = 1'b0;
    w0 = wr_cnt;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    disp_req = 1'b0;
    @(negedge clk);
    check("rst2_ready", host_if.ready, 1);
    check("rst2_rvalid", disp_rvalid, 0);
    check("rst2_mem_we", mem_we, 0);
    repeat (20) tick();
    check("rst2_no_writes", wr_cnt - w0, 0);
    count_mism(mism);
    check("rst2_sram", mism, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
